// File: rtl/dmg_timer.sv
// rtl/dmg_timer.sv - programmable timer: TIMA counter, TMA reload, TAC tap select, overflow interrupt
module dmg_timer #(
    parameter logic [7:0] TMA_RESET  = 8'h00,
    parameter logic [4:0] TAC_UNUSED = 5'b11111
) (
    input  logic       boga1mhz,
    input  logic       reset,
    inout  wire  [7:0] d,
    input  logic       cpu_wr,
    input  logic       cpu_rd,
    input  logic       ff04_ff07,
    input  logic       tovy_na0,
    input  logic       tola_na1,
    input  logic       _4096hz,
    input  logic       _262144hz,
    input  logic       _65536hz,
    input  logic       _16384hz,
    output logic       int_timer
);

    logic [7:0] tima_q, tima_d;
    logic [7:0] tma_q, tma_d;
    logic [2:0] tac_q, tac_d;
    logic       tick_prev_q, tick_prev_d;
    logic       ovf_pending_q, ovf_pending_d;
    logic       int_timer_q, int_timer_d;

    logic       sel_tima, sel_tma, sel_tac;
    logic       tima_wr, tma_wr, tac_wr;
    logic       tap_sel, tick_in, inc;
    logic [7:0] rdata;
    logic       rd_en;

    // Address decode, tap mux and falling-edge increment detection
    always_comb begin
        sel_tima = ff04_ff07 &  tola_na1 & ~tovy_na0;
        sel_tma  = ff04_ff07 & ~tola_na1 &  tovy_na0;
        sel_tac  = ff04_ff07 & ~tola_na1 & ~tovy_na0;
        tima_wr  = cpu_wr & sel_tima;
        tma_wr   = cpu_wr & sel_tma;
        tac_wr   = cpu_wr & sel_tac;
        case (tac_q[1:0])
            2'b00:   tap_sel = _4096hz;
            2'b01:   tap_sel = _262144hz;
            2'b10:   tap_sel = _65536hz;
            default: tap_sel = _16384hz;
        endcase
        // TAC writes and divider resets can produce a falling edge here; those count too
        tick_in = tap_sel & tac_q[2];
        inc     = tick_prev_q & ~tick_in;
    end

    // Next-state: TIMA counting, overflow pending cycle, reload and interrupt
    always_comb begin
        tima_d        = tima_q;
        tma_d         = tma_wr ? d : tma_q;
        tac_d         = tac_wr ? d[2:0] : tac_q;
        tick_prev_d   = tick_in;
        ovf_pending_d = 1'b0;
        int_timer_d   = 1'b0;
        if (ovf_pending_q) begin
            // Pending cycle: a TIMA write cancels the reload; increments are dropped
            if (tima_wr) begin
                tima_d = d;
            end else begin
                tima_d      = tma_d;
                int_timer_d = 1'b1;
            end
        end else if (tima_wr && !int_timer_q) begin
            // Write beats a coincident increment; in the reload cycle the write is ignored
            tima_d = d;
        end else if (inc) begin
            if (tima_q == 8'hFF) begin
                tima_d        = 8'h00;
                ovf_pending_d = 1'b1;
            end else begin
                tima_d = tima_q + 8'h01;
            end
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge boga1mhz or posedge reset) begin
        if (reset) begin
            tima_q        <= 8'h00;
            tma_q         <= TMA_RESET;
            tac_q         <= 3'b000;
            tick_prev_q   <= 1'b0;
            ovf_pending_q <= 1'b0;
            int_timer_q   <= 1'b0;
        end else begin
            tima_q        <= tima_d;
            tma_q         <= tma_d;
            tac_q         <= tac_d;
            tick_prev_q   <= tick_prev_d;
            ovf_pending_q <= ovf_pending_d;
            int_timer_q   <= int_timer_d;
        end
    end

    // Combinational register read onto the shared data bus
    always_comb begin
        rdata = 8'h00;
        if (sel_tima)     rdata = tima_q;
        else if (sel_tma) rdata = tma_q;
        else if (sel_tac) rdata = {TAC_UNUSED, tac_q};
        rd_en = cpu_rd & (sel_tima | sel_tma | sel_tac);
    end

    assign d         = rd_en ? rdata : 8'bzzzz_zzzz;
    assign int_timer = int_timer_q;

endmodule
